// File: rtl/dynamic_delay_ctrl.sv
// -----------------------------------------------------------------------------
// dynamic_delay_ctrl
//
// Run-time controller for a dynamic_delay tap line. It accepts tap-change
// requests over a valid/ready handshake, drives the line's sel/ena inputs, and
// holds out_valid low after a tap jump until the line output again contains
// only samples taken at the new delay.
//
// Optional feature macro: DYNAMIC_DELAY_CTRL_RAMP_EN
//   undefined : a tap change jumps dd_sel and blanks out_valid for tap+2
//               enabled cycles.
//   defined   : a tap change ramps dd_sel by one tap per enabled cycle toward
//               the target, with out_valid kept high. Post-reset blanking is
//               still applied.
//
// Parameters
//   LENGTH     tap count of the controlled delay line
//   SEL_W      tap selector width
//
// Ports
//   clk        in   system clock
//   nrst       in   asynchronous active-low reset
//   ena        in   global clock enable, passed straight through to dd_ena
//   req_valid  in   tap request present
//   req_sel    in   requested tap
//   req_ready  out  controller can accept a request
//   dd_ena     out  delay line ena
//   dd_sel     out  delay line sel (registered)
//   out_valid  out  delay line output is settled for the current tap
//   err        out  one-cycle pulse after an out-of-range request is accepted
// -----------------------------------------------------------------------------
module dynamic_delay_ctrl #(
   parameter int LENGTH = 8,
   parameter int SEL_W  = $clog2(LENGTH)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             ena,
   input  logic             req_valid,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   output logic             dd_ena,
   output logic [SEL_W-1:0] dd_sel,
   output logic             out_valid,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_SETTLE,
      ST_RAMP
   } state_t;

   // Counter is one bit wider than the selector so LENGTH+1 fits without wrap.
   localparam logic [SEL_W:0]   LEN_C    = (SEL_W+1)'(LENGTH);
   localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(LENGTH-1);
   localparam logic [SEL_W:0]   INIT_CNT = (SEL_W+1)'(2);

   state_t           r_state;
   logic [SEL_W:0]   r_cnt;

   logic             w_accept;
   logic             w_clamp;
   logic [SEL_W-1:0] w_tap;
   logic [SEL_W:0]   w_cnt_dec;
   logic [SEL_W:0]   w_settle_len;

   assign dd_ena   = ena;
   assign w_accept = req_valid & req_ready;

   // Out-of-range detection only fires for non-power-of-2 LENGTH; the
   // zero-extension keeps the compare well-formed for every LENGTH.
   always_comb begin
      w_clamp      = ({1'b0, req_sel} >= LEN_C);
      w_tap        = w_clamp ? LAST_TAP : req_sel;
      w_settle_len = {1'b0, w_tap} + INIT_CNT;
   end

   assign w_cnt_dec = r_cnt - 1'b1;

`ifdef DYNAMIC_DELAY_CTRL_RAMP_EN
   logic [SEL_W-1:0] r_target;
   logic [SEL_W-1:0] w_goal;
   logic [SEL_W-1:0] w_step;

   // In IDLE the target is still on req_sel, so the first step can be taken
   // on the acceptance edge itself.
   always_comb begin
      w_goal = (r_state == ST_IDLE) ? w_tap : r_target;
      w_step = (w_goal > dd_sel) ? (dd_sel + 1'b1) : (dd_sel - 1'b1);
   end
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= ST_INIT;
         r_cnt     <= '0;
         dd_sel    <= '0;
         req_ready <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
`ifdef DYNAMIC_DELAY_CTRL_RAMP_EN
         r_target  <= '0;
`endif
      end else begin
         err <= 1'b0;
         case (r_state)
            ST_INIT: begin
               if (ena) begin
                  r_cnt   <= INIT_CNT;
                  r_state <= ST_SETTLE;
               end
            end

            ST_SETTLE: begin
               // Line does not shift while ena=0, so the count freezes too.
               if (ena) begin
                  r_cnt <= w_cnt_dec;
                  if (w_cnt_dec == '0) begin
                     r_state   <= ST_IDLE;
                     req_ready <= 1'b1;
                     out_valid <= 1'b1;
                  end
               end
            end

            ST_IDLE: begin
               if (w_accept) begin
                  err <= w_clamp;
                  // A request for the current tap is a no-op: no blanking.
                  if (w_tap != dd_sel) begin
`ifdef DYNAMIC_DELAY_CTRL_RAMP_EN
                     r_target <= w_tap;
                     if (ena) begin
                        dd_sel <= w_step;
                        if (w_step != w_tap) begin
                           r_state   <= ST_RAMP;
                           req_ready <= 1'b0;
                        end
                     end else begin
                        r_state   <= ST_RAMP;
                        req_ready <= 1'b0;
                     end
`else
                     dd_sel    <= w_tap;
                     r_cnt     <= w_settle_len;
                     r_state   <= ST_SETTLE;
                     req_ready <= 1'b0;
                     out_valid <= 1'b0;
`endif
                  end
               end
            end

`ifdef DYNAMIC_DELAY_CTRL_RAMP_EN
            ST_RAMP: begin
               if (ena) begin
                  dd_sel <= w_step;
                  if (w_step == r_target) begin
                     r_state   <= ST_IDLE;
                     req_ready <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               r_state   <= ST_INIT;
               req_ready <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
